// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

  // Low PC bits that must be zero for a 4-byte aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    ERR     = 3'd4
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return |(pc_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait counter for outstanding memory requests; expired marks the last
// cycle a request may still be acknowledged.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: runs the memory req/ack handshake for each accepted PC and
// presents {instruction, pc} to decode under valid/ready, with flush and timeout handling.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               fetch_stall,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
);

  fetch_state_t       state_reg, state_next;
  logic               mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [INSTR_W-1:0] instr_out_reg, instr_out_next;
  logic [ADDR_W-1:0]  instr_pc_reg, instr_pc_next;
  logic               instr_valid_reg, instr_valid_next;
  logic               fetch_err_reg, fetch_err_next;

  logic accept;
  logic timer_clr, timer_inc, timer_expired;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // No mem_ack term here, so the PC source never sees a memory-to-stall path.
  assign accept = pc_valid && !flush &&
                  ((state_reg == IDLE) || ((state_reg == HOLD) && instr_ready));
  assign fetch_stall = pc_valid && !flush && !accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      instr_out_reg   <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      instr_out_reg   <= instr_out_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
      fetch_err_reg   <= fetch_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    mem_req_next     = mem_req_reg;
    mem_addr_next    = mem_addr_reg;
    instr_out_next   = instr_out_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;
    fetch_err_next   = fetch_err_reg;
    timer_clr        = 1'b0;
    timer_inc        = 1'b0;

    // A new fetch can start from IDLE or from HOLD once decode takes the current word.
    if (accept) begin
      if (pc_misaligned(pc_in[1:0])) begin
        state_next     = ERR;
        fetch_err_next = 1'b1;
        mem_req_next   = 1'b0;
      end else begin
        state_next    = REQ;
        mem_req_next  = 1'b1;
        mem_addr_next = pc_in;
        timer_clr     = 1'b1;
      end
    end

    unique case (state_reg)
      IDLE: begin
        if (flush) begin
          instr_valid_next = 1'b0;
        end
      end
      REQ: begin
        if (flush) begin
          if (mem_ack) begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end else begin
            // The request cannot be retracted; wait out its ack and drop the data.
            state_next = DISCARD;
            timer_clr  = 1'b1;
          end
        end else if (mem_ack) begin
          state_next       = HOLD;
          mem_req_next     = 1'b0;
          instr_out_next   = mem_rdata;
          instr_pc_next    = mem_addr_reg;
          instr_valid_next = 1'b1;
        end else if (timer_expired) begin
          state_next     = ERR;
          mem_req_next   = 1'b0;
          fetch_err_next = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next       = IDLE;
          instr_valid_next = 1'b0;
        end else if (instr_ready) begin
          instr_valid_next = 1'b0;
          if (!accept) begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end else if (timer_expired) begin
          state_next     = ERR;
          mem_req_next   = 1'b0;
          fetch_err_next = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ERR: begin
        mem_req_next     = 1'b0;
        instr_valid_next = 1'b0;
        if (flush) begin
          state_next     = IDLE;
          fetch_err_next = 1'b0;
        end
      end
      default: begin
        state_next       = IDLE;
        mem_req_next     = 1'b0;
        instr_valid_next = 1'b0;
      end
    endcase
  end

  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr_out   = instr_out_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign fetch_err   = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: basic fetch, back-to-back, decode stall,
// flush, misalignment, timeout and asynchronous reset.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int TIMEOUT = 16;

  logic               clk;
  logic               reset;
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               fetch_stall;
  logic               flush;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               fetch_err;

  int n_vec;
  int n_bad;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    reset       = 1'b0;
    pc_in       = '0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;

    #3;
    check_vec("rst_mem_req", 64'(mem_req), 64'd0);
    check_vec("rst_mem_addr", mem_addr, 64'd0);
    check_vec("rst_instr_valid", 64'(instr_valid), 64'd0);
    check_vec("rst_instr_out", 64'(instr_out), 64'd0);
    check_vec("rst_fetch_err", 64'(fetch_err), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Basic fetch: ack arrives in the third request cycle.
    pc_in    = 64'h40;
    pc_valid = 1'b1;
    #1 check_vec("basic_stall_idle", 64'(fetch_stall), 64'd0);
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("basic_req_%0d", i), 64'(mem_req), 64'd1);
      check_vec($sformatf("basic_addr_%0d", i), mem_addr, 64'h40);
      check_vec($sformatf("basic_nvalid_%0d", i), 64'(instr_valid), 64'd0);
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h8B020020;
      end
      step();
    end
    mem_ack = 1'b0;
    check_vec("basic_valid", 64'(instr_valid), 64'd1);
    check_vec("basic_instr", 64'(instr_out), 64'h8B020020);
    check_vec("basic_pc", instr_pc, 64'h40);
    check_vec("basic_req_drop", 64'(mem_req), 64'd0);
    instr_ready = 1'b1;
    step();
    check_vec("basic_consumed", 64'(instr_valid), 64'd0);

    // Back-to-back fetches of 0, 4, 8 with single-cycle ack.
    pc_in    = 64'h0;
    pc_valid = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("b2b_req_%0d", k), 64'(mem_req), 64'd1);
      check_vec($sformatf("b2b_addr_%0d", k), mem_addr, 64'(4 * k));
      check_vec($sformatf("b2b_stall_req_%0d", k), 64'(fetch_stall), 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA0000000 | 32'(k);
      if (k < 2) pc_in = 64'(4 * (k + 1));
      else pc_valid = 1'b0;
      step();
      mem_ack = 1'b0;
      check_vec($sformatf("b2b_valid_%0d", k), 64'(instr_valid), 64'd1);
      check_vec($sformatf("b2b_pc_%0d", k), instr_pc, 64'(4 * k));
      check_vec($sformatf("b2b_instr_%0d", k), 64'(instr_out), 64'(32'hA0000000 | 32'(k)));
      if (k < 2) begin
        #1 check_vec($sformatf("b2b_stall_hold_%0d", k), 64'(fetch_stall), 64'd0);
      end
      step();
    end
    check_vec("b2b_idle", 64'(instr_valid), 64'd0);

    // Decode stall: instr_ready low for 5 cycles while the next PC waits.
    instr_ready = 1'b0;
    pc_in       = 64'h200;
    pc_valid    = 1'b1;
    step();
    pc_in     = 64'h204;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_vec($sformatf("stall_valid_%0d", i), 64'(instr_valid), 64'd1);
      check_vec($sformatf("stall_instr_%0d", i), 64'(instr_out), 64'h12345678);
      check_vec($sformatf("stall_flag_%0d", i), 64'(fetch_stall), 64'd1);
      check_vec($sformatf("stall_noreq_%0d", i), 64'(mem_req), 64'd0);
      step();
    end
    instr_ready = 1'b1;
    #1 check_vec("stall_release", 64'(fetch_stall), 64'd0);
    step();
    check_vec("stall_next_addr", mem_addr, 64'h204);
    check_vec("stall_next_req", 64'(mem_req), 64'd1);
    pc_valid = 1'b0;
    mem_ack  = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    check_vec("stall_drained", 64'(instr_valid), 64'd0);

    // Flush in IDLE with a valid PC: stall drops, nothing is accepted.
    pc_in    = 64'h500;
    pc_valid = 1'b1;
    flush    = 1'b1;
    #1 check_vec("flush_idle_stall", 64'(fetch_stall), 64'd0);
    step();
    check_vec("flush_idle_noreq", 64'(mem_req), 64'd0);
    flush    = 1'b0;
    pc_valid = 1'b0;

    // Flush while waiting for ack; the stale data must be dropped.
    pc_in    = 64'h80;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check_vec("flush_req_held", 64'(mem_req), 64'd1);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check_vec("flush_drop_valid", 64'(instr_valid), 64'd0);
    check_vec("flush_drop_req", 64'(mem_req), 64'd0);
    step();
    check_vec("flush_still_idle", 64'(instr_valid), 64'd0);
    pc_in    = 64'h100;
    pc_valid = 1'b1;
    step();
    pc_valid  = 1'b0;
    check_vec("flush_next_addr", mem_addr, 64'h100);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE0100;
    step();
    mem_ack = 1'b0;
    check_vec("flush_next_instr", 64'(instr_out), 64'hCAFE0100);
    check_vec("flush_next_pc", instr_pc, 64'h100);
    step();

    // Misaligned PC.
    pc_in    = 64'h42;
    pc_valid = 1'b1;
    step();
    check_vec("misal_err", 64'(fetch_err), 64'd1);
    check_vec("misal_stall", 64'(fetch_stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("misal_noreq_%0d", i), 64'(mem_req), 64'd0);
      step();
    end
    check_vec("misal_sticky", 64'(fetch_err), 64'd1);
    flush = 1'b1;
    #1 check_vec("misal_flush_stall", 64'(fetch_stall), 64'd0);
    step();
    flush    = 1'b0;
    pc_valid = 1'b0;
    check_vec("misal_cleared", 64'(fetch_err), 64'd0);

    // Ack timeout: request stays up for exactly TIMEOUT cycles.
    pc_in    = 64'h300;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        check_vec($sformatf("tmo_wait_%0d", i), {mem_req, fetch_err}, 64'b10);
      end
      step();
    end
    check_vec("tmo_err", 64'(fetch_err), 64'd1);
    check_vec("tmo_req_drop", 64'(mem_req), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_vec("tmo_cleared", 64'(fetch_err), 64'd0);

    // Asynchronous reset in the middle of a request.
    pc_in    = 64'h400;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    check_vec("arst_pre_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_vec("arst_req", 64'(mem_req), 64'd0);
    check_vec("arst_valid", 64'(instr_valid), 64'd0);
    check_vec("arst_err", 64'(fetch_err), 64'd0);
    check_vec("arst_addr", mem_addr, 64'd0);
    #2 reset = 1'b1;
    step();
    check_vec("arst_after_req", 64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
